// File: rtl/jtdsp16_rom_fetch_pkg.sv
// jtdsp16_rom_fetch_pkg: shared widths and fill FSM states for the program ROM fetch unit
package jtdsp16_rom_fetch_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE, DFILL, PFILL} fsm_t;
endpackage

// File: rtl/jtdsp16_rom_fetch_if.sv
// jtdsp16_rom_fetch_if: cs/ok word-read handshake towards the external memory controller
interface jtdsp16_rom_fetch_if
  import jtdsp16_rom_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [AW-1:0] ext_addr;
  logic          ext_cs;
  logic [DW-1:0] ext_data;
  logic          ext_ok;
  modport master (output ext_addr, ext_cs, input ext_data, ext_ok);
  modport slave  (input ext_addr, ext_cs, output ext_data, ext_ok);
endinterface

// File: rtl/jtdsp16_rom_fetch_buf.sv
// jtdsp16_rom_fetch_buf: direct-mapped word buffer with demand and prefetch lookup ports
module jtdsp16_rom_fetch_buf
  import jtdsp16_rom_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic          o_hit,
  output logic [DW-1:0] o_rdata,
  input  logic [AW-1:0] i_paddr,
  output logic          o_phit
);
  localparam int N = 1 << LW;
  logic [N-1:0]    r_valid;
  logic [AW-LW-1:0] r_tag [N];
  logic [DW-1:0]   r_data [N];
  assign o_hit   = r_valid[i_raddr[LW-1:0]] && r_tag[i_raddr[LW-1:0]] == i_raddr[AW-1:LW];
  assign o_phit  = r_valid[i_paddr[LW-1:0]] && r_tag[i_paddr[LW-1:0]] == i_paddr[AW-1:LW];
  assign o_rdata = r_data[i_raddr[LW-1:0]];
  // valid bits: flush or reset empties the whole buffer, a fill marks its slot
  always_ff @(posedge clk) begin
    if (rst || i_flush) r_valid <= '0;
    else if (i_we) r_valid[i_waddr[LW-1:0]] <= 1'b1;
  end
  // tag/data storage needs no reset, it is masked by the valid bit
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_waddr[LW-1:0]]  <= i_waddr[AW-1:LW];
      r_data[i_waddr[LW-1:0]] <= i_wdata;
    end
  end
endmodule

// File: rtl/jtdsp16_rom_fetch.sv
// jtdsp16_rom_fetch: serves DSP program words from a small buffer filled over a cs/ok bus
module jtdsp16_rom_fetch
  import jtdsp16_rom_fetch_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int LW   = 2,
  parameter int PREF = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cen,
  input  logic          i_flush,
  input  logic [AW-1:0] i_rom_addr,
  output logic [DW-1:0] o_rom_dout,
  output logic          o_rom_ok,
  output logic          o_dsp_cen,
  jtdsp16_rom_fetch_if.master ext
);
  fsm_t          r_st;
  logic          r_cs;
  logic          r_first;
  logic          r_drop;
  logic [AW-1:0] r_addr;
  logic          w_hit;
  logic          w_nhit;
  logic          w_we;
  logic [AW-1:0] w_naddr;
  logic [DW-1:0] w_rdata;
  assign w_naddr      = i_rom_addr + AW'(1);
  assign w_we         = r_st != IDLE && !r_first && ext.ext_ok && !r_drop && !i_flush;
  assign o_rom_ok     = w_hit;
  assign o_rom_dout   = w_hit ? w_rdata : '0;
  assign o_dsp_cen    = i_cen & w_hit;
  assign ext.ext_addr = r_addr;
  assign ext.ext_cs   = r_cs;
  jtdsp16_rom_fetch_buf #(.AW(AW), .DW(DW), .LW(LW)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_flush(i_flush),
    .i_we   (w_we),
    .i_waddr(r_addr),
    .i_wdata(ext.ext_data),
    .i_raddr(i_rom_addr),
    .o_hit  (w_hit),
    .o_rdata(w_rdata),
    .i_paddr(w_naddr),
    .o_phit (w_nhit)
  );
  // fill sequencer: demand miss first, else prefetch next word; a fill always runs to its ok
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_cs    <= 1'b0;
      r_addr  <= '0;
      r_first <= 1'b0;
      r_drop  <= 1'b0;
    end else if (r_st == IDLE) begin
      r_first <= 1'b1;
      r_drop  <= 1'b0;
      if (!w_hit && !i_flush) begin
        r_st   <= DFILL;
        r_addr <= i_rom_addr;
        r_cs   <= 1'b1;
      end else if (w_hit && PREF != 0 && !w_nhit) begin
        r_st   <= PFILL;
        r_addr <= w_naddr;
        r_cs   <= 1'b1;
      end
    end else begin
      r_first <= 1'b0;
      if (!r_first && ext.ext_ok) begin
        r_st   <= IDLE;
        r_cs   <= 1'b0;
        r_drop <= 1'b0;
      end else if (i_flush) r_drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtdsp16_rom_fetch.sv
// tb_jtdsp16_rom_fetch: directed and random program fetches checked against an address-keyed buffer model
module tb_jtdsp16_rom_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rom_addr = 16'h0;
  logic [15:0] rom_dout;
  logic        rom_ok;
  logic        dsp_cen;
  jtdsp16_rom_fetch_if #(.AW(16), .DW(16)) ext ();
  jtdsp16_rom_fetch #(.AW(16), .DW(16), .LW(2), .PREF(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_cen     (cen),
    .i_flush   (flush),
    .i_rom_addr(rom_addr),
    .o_rom_dout(rom_dout),
    .o_rom_ok  (rom_ok),
    .o_dsp_cen (dsp_cen),
    .ext       (ext)
  );
  always #5 clk = ~clk;
  logic [15:0] m_tag [4];
  logic [15:0] m_dat [4];
  logic        m_v [4];
  logic        m_cs = 1'b0;
  logic        m_drop = 1'b0;
  logic [15:0] m_addr = 16'h0;
  int          m_age = 0;
  int          lat = 1;
  bit          ok_always = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  function automatic logic [15:0] mem_word(logic [15:0] a);
    return a == 16'h0 ? 16'h1234 : {a[7:0] ^ 8'h3C, a[15:8] + 8'h71};
  endfunction
  function automatic bit m_hit(logic [15:0] a);
    return m_v[a[1:0]] && m_tag[a[1:0]] == a;
  endfunction
  function automatic logic [15:0] m_out(logic [15:0] a);
    return m_hit(a) ? m_dat[a[1:0]] : 16'h0;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("rom_ok", {31'h0, rom_ok}, {31'h0, m_hit(rom_addr)});
    chk("rom_dout", {16'h0, rom_dout}, {16'h0, m_out(rom_addr)});
    chk("dsp_cen", {31'h0, dsp_cen}, {31'h0, cen & m_hit(rom_addr)});
    chk("ext_cs", {31'h0, ext.ext_cs}, {31'h0, m_cs});
    chk("ext_addr", {16'h0, ext.ext_addr}, {16'h0, m_addr});
  endtask
  task automatic start_fill(logic [15:0] a);
    m_cs = 1'b1;
    m_addr = a;
    m_age = 0;
    m_drop = 1'b0;
  endtask
  task automatic model_edge();
    bit h, hn, acc;
    logic [15:0] na;
    na = rom_addr + 16'd1;
    h = m_hit(rom_addr);
    hn = m_hit(na);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      m_cs = 1'b0;
      m_addr = 16'h0;
      m_drop = 1'b0;
      m_age = 0;
    end else begin
      acc = m_cs && m_age >= 1 && ext.ext_ok;
      if (acc && !m_drop && !flush) begin
        m_v[m_addr[1:0]] = 1'b1;
        m_tag[m_addr[1:0]] = m_addr;
        m_dat[m_addr[1:0]] = mem_word(m_addr);
      end
      if (flush) for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      if (!m_cs) begin
        if (!h && !flush) start_fill(rom_addr);
        else if (h && !hn) start_fill(na);
      end else if (acc) begin
        m_cs = 1'b0;
        m_drop = 1'b0;
      end else begin
        m_age++;
        if (flush) m_drop = 1'b1;
      end
    end
  endtask
  task automatic drive_resp();
    ext.ext_ok = ok_always || (m_cs && m_age >= lat);
    ext.ext_data = mem_word(ext.ext_addr);
  endtask
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    drive_resp();
  endtask
  initial begin
    bit adv;
    int r;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = 16'h0;
      m_dat[i] = 16'h0;
    end
    ext.ext_ok = 1'b0;
    ext.ext_data = 16'h0;
    @(posedge clk);
    model_edge();
    #1;
    drive_resp();
    tick();
    #1;
    chk("reset_rom_ok", {31'h0, rom_ok}, 32'h0);
    chk("reset_ext_cs", {31'h0, ext.ext_cs}, 32'h0);
    rst = 1'b0;
    cen = 1'b1;
    rom_addr = 16'h0;
    lat = 1;
    repeat (6) tick();
    #1;
    chk("first_ok", {31'h0, rom_ok}, 32'h1);
    chk("first_dout", {16'h0, rom_dout}, 32'h1234);
    chk("first_dsp_cen", {31'h0, dsp_cen}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    lat = 3;
    for (int c = 0; c < 200 && rom_addr < 16'd8; c++) begin
      cen = (c % 4) == 3;
      adv = cen && m_hit(rom_addr);
      tick();
      if (adv) rom_addr = rom_addr + 16'd1;
    end
    chk("seq_reached_8", {16'h0, rom_addr}, 32'h8);
    cen = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ok_always = 1'b1;
    rom_addr = 16'h0040;
    repeat (12) tick();
    ok_always = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rom_addr = 16'h0004;
    lat = 3;
    for (int c = 0; c < 30 && !(ext.ext_cs && ext.ext_addr == 16'h5); c++) tick();
    #1;
    chk("pref5_issued", {16'h0, ext.ext_addr}, 32'h5);
    rom_addr = 16'h0100;
    repeat (16) tick();
    #1;
    chk("jump_ok", {31'h0, rom_ok}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rom_addr = 16'h0003;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (14) tick();
    #1;
    chk("refetch3_ok", {31'h0, rom_ok}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rom_addr = 16'hFFFF;
    lat = 1;
    repeat (4) tick();
    for (int c = 0; c < 10 && !(ext.ext_cs && ext.ext_addr == 16'h0); c++) tick();
    #1;
    chk("wrap_cs", {31'h0, ext.ext_cs}, 32'h1);
    chk("wrap_addr", {16'h0, ext.ext_addr}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midfill_rst_cs", {31'h0, ext.ext_cs}, 32'h0);
    chk("midfill_rst_ok", {31'h0, rom_ok}, 32'h0);
    chk("midfill_rst_cen", {31'h0, dsp_cen}, 32'h0);
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom_range(0, 99));
      adv = cen && m_hit(rom_addr);
      if (r < 50 && adv) rom_addr = rom_addr + 16'd1;
      else if (r < 60) rom_addr = 16'($urandom_range(0, 15));
      else if (r < 63) rom_addr = 16'hFFFE + 16'($urandom_range(0, 1));
      flush = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 199) == 0;
      cen = 1'($urandom_range(0, 1));
      if (c % 50 == 0) begin
        lat = int'($urandom_range(1, 4));
        ok_always = $urandom_range(0, 4) == 0;
      end
      tick();
    end
    flush = 1'b0;
    rst = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
